// File: rtl/arm_mem_pkg.sv
// Shared types and IR field positions for the ARM load/store-multiple datapath.
// Mode enum is encoded as {U,P} so it can be cast straight from the instruction bits.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        DA = 2'b00,
        DB = 2'b01,
        IA = 2'b10,
        IB = 2'b11
    } addr_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        WB,
        FIN
    } seq_state_t;

    localparam int         L_BIT        = 20;
    localparam int         W_BIT        = 21;
    localparam int         U_BIT        = 23;
    localparam int         P_BIT        = 24;
    localparam int         RN_LSB       = 16;
    localparam logic [2:0] CLASS_LDMSTM = 3'b100;

endpackage

// File: rtl/reg_list_scan.sv
// Register-list scanner: lowest set index, non-empty flag and popcount of the mask.
// Purely combinational, zero latency; no flow control.
module reg_list_scan #(
    parameter  int NUM_REGS = 16,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0] mask,
    output logic [IDX_W-1:0]    low_idx,
    output logic                any,
    output logic [IDX_W:0]      count
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        low_idx = '0;
        count   = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = IDX_W'(i);
            end
            count = count + {{IDX_W{1'b0}}, mask[i]};
        end
    end

    assign any = |mask;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: one word address per listed register, MFA/MOC handshake, base write-back.
// START to DONE is 1 + (2n-1) + W + 1 cycles minimum; each transfer holds MFA until MOC, unbounded.
module ldm_stm_sequencer
    import arm_mem_pkg::*;
#(
    parameter  int NUM_REGS   = 16,
    parameter  int ADDR_W     = 32,
    parameter  int WORD_BYTES = 4,
    localparam int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] BASE,
    input  logic              MOC,
    output logic              MFA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RW,
    output logic [IDX_W-1:0]  REG_IDX,
    output logic              REG_LD,
    output logic              WB_EN,
    output logic [3:0]        WB_REG,
    output logic [ADDR_W-1:0] WB_VALUE,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    seq_state_t          state, state_nxt;
    addr_mode_t          mode;
    logic                l_q, w_q, u_q, p_q, rn_listed_q, gap_q, reg_ld_q;
    logic [3:0]          rn_q;
    logic [NUM_REGS-1:0] mask_q;
    logic [IDX_W-1:0]    idx_q, low_idx;
    logic [IDX_W:0]      count;
    logic                any, accept, xfer_act, rn_listed, unused_ir;
    logic [15:0]         list16;
    logic [ADDR_W-1:0]   base_q, addr_q, wb_q, span, start_addr, wb_calc;

    reg_list_scan #(.NUM_REGS(NUM_REGS)) u_scan (
        .mask    (mask_q),
        .low_idx (low_idx),
        .any     (any),
        .count   (count)
    );

    assign accept    = START && (IR[27:25] == CLASS_LDMSTM);
    assign list16    = 16'(IR[NUM_REGS-1:0]);
    assign rn_listed = list16[IR[RN_LSB +: 4]];
    assign unused_ir = ^{IR[31:28], IR[22], IR[15:0]};
    assign mode      = addr_mode_t'({u_q, p_q});
    assign xfer_act  = (state == XFER) && !gap_q;

    always_comb begin
        span       = ADDR_W'(count) * STEP;
        start_addr = base_q;
        case (mode)
            IA:      start_addr = base_q;
            IB:      start_addr = base_q + STEP;
            DA:      start_addr = base_q - span + STEP;
            default: start_addr = base_q - span;
        endcase
        wb_calc = u_q ? (base_q + span) : (base_q - span);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        MFA       = xfer_act;
        BUSY      = (state != IDLE);
        DONE      = (state == FIN);
        // A register reloaded from memory must not be clobbered by the base update.
        WB_EN     = (state == WB) && !(l_q && rn_listed_q);
        case (state)
            IDLE:  if (accept) state_nxt = SETUP;
            SETUP: state_nxt = any ? XFER : FIN;
            XFER:  if (xfer_act && MOC && (count == {{IDX_W{1'b0}}, 1'b1}))
                       state_nxt = w_q ? WB : FIN;
            WB:    state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            l_q         <= 1'b0;
            w_q         <= 1'b0;
            u_q         <= 1'b0;
            p_q         <= 1'b0;
            rn_q        <= '0;
            rn_listed_q <= 1'b0;
            base_q      <= '0;
            mask_q      <= '0;
            addr_q      <= '0;
            wb_q        <= '0;
            idx_q       <= '0;
            gap_q       <= 1'b0;
            reg_ld_q    <= 1'b0;
        end else begin
            reg_ld_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    l_q         <= IR[L_BIT];
                    w_q         <= IR[W_BIT];
                    u_q         <= IR[U_BIT];
                    p_q         <= IR[P_BIT];
                    rn_q        <= IR[RN_LSB +: 4];
                    rn_listed_q <= rn_listed;
                    base_q      <= BASE;
                    mask_q      <= IR[NUM_REGS-1:0];
                    gap_q       <= 1'b0;
                end
                SETUP: begin
                    addr_q <= start_addr;
                    wb_q   <= wb_calc;
                    idx_q  <= low_idx;
                end
                // idx_q advances only at the end of the gap cycle so REG_LD sees the completed index.
                XFER: if (gap_q) begin
                    gap_q <= 1'b0;
                    idx_q <= low_idx;
                end else if (MOC) begin
                    mask_q[idx_q] <= 1'b0;
                    addr_q        <= addr_q + STEP;
                    reg_ld_q      <= l_q;
                    gap_q         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign MEM_ADDR = addr_q;
    assign MEM_RW   = l_q;
    assign REG_IDX  = idx_q;
    assign REG_LD   = reg_ld_q;
    assign WB_REG   = rn_q;
    assign WB_VALUE = wb_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed LDM/STM vectors push expected events,
// a negedge monitor pops and compares transfers, register loads, write-backs and DONE timing.
module tb_ldm_stm_sequencer;

    logic        CLK, RESET_N, START, MOC;
    logic [31:0] IR, BASE;
    logic        MFA, MEM_RW, REG_LD, WB_EN, BUSY, DONE;
    logic [31:0] MEM_ADDR, WB_VALUE;
    logic [3:0]  REG_IDX, WB_REG;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  idx;
        logic        rw;
    } xfer_t;

    typedef struct packed {
        logic [3:0]  rn;
        logic [31:0] val;
    } wb_t;

    xfer_t      xfer_q[$];
    logic [3:0] ld_q[$];
    wb_t        wb_q[$];
    int         done_q[$];

    ldm_stm_sequencer dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .START    (START),
        .IR       (IR),
        .BASE     (BASE),
        .MOC      (MOC),
        .MFA      (MFA),
        .MEM_ADDR (MEM_ADDR),
        .MEM_RW   (MEM_RW),
        .REG_IDX  (REG_IDX),
        .REG_LD   (REG_LD),
        .WB_EN    (WB_EN),
        .WB_REG   (WB_REG),
        .WB_VALUE (WB_VALUE),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
    endtask

    function automatic logic [95:0] outs();
        return {18'b0, MFA, MEM_ADDR, MEM_RW, REG_IDX, REG_LD, WB_EN, WB_REG, WB_VALUE, BUSY, DONE};
    endfunction

    // Monitor: samples on the falling edge, decoupled from stimulus.
    initial begin
        xfer_t       ex;
        wb_t         ew;
        logic [3:0]  el;
        int          ed;
        logic        prev_mfa, prev_moc, prev_rw;
        logic [31:0] prev_addr;
        logic [3:0]  prev_idx;
        prev_mfa  = 1'b0;
        prev_moc  = 1'b0;
        prev_rw   = 1'b0;
        prev_addr = '0;
        prev_idx  = '0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                prev_mfa = 1'b0;
                prev_moc = 1'b0;
            end else begin
                if (prev_mfa && !prev_moc)
                    check("stall_hold", {MFA, MEM_ADDR, REG_IDX}, {1'b1, prev_addr, prev_idx});
                if (MFA && MOC) begin
                    if (xfer_q.size() == 0) unexpected("xfer");
                    else begin
                        ex = xfer_q.pop_front();
                        check("xfer", {MEM_ADDR, REG_IDX, MEM_RW}, ex);
                    end
                end
                if (REG_LD) begin
                    check("ld_after_moc", {prev_mfa, prev_moc, prev_rw}, 3'b111);
                    if (ld_q.size() == 0) unexpected("reg_ld");
                    else begin
                        el = ld_q.pop_front();
                        check("reg_ld_idx", REG_IDX, el);
                    end
                end
                if (WB_EN) begin
                    if (wb_q.size() == 0) unexpected("wb_en");
                    else begin
                        ew = wb_q.pop_front();
                        check("wb", {WB_REG, WB_VALUE}, ew);
                    end
                end
                if (DONE) begin
                    if (done_q.size() == 0) unexpected("done");
                    else begin
                        ed = done_q.pop_front();
                        check("done_cycle", cyc, ed);
                    end
                end
                prev_mfa  = MFA;
                prev_moc  = MOC;
                prev_rw   = MEM_RW;
                prev_addr = MEM_ADDR;
                prev_idx  = REG_IDX;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_x(input logic [31:0] a, input logic [3:0] i, input logic rw);
        xfer_q.push_back({a, i, rw});
    endtask

    task automatic exp_wb(input logic [3:0] rn, input logic [31:0] v);
        wb_q.push_back({rn, v});
    endtask

    // lat < 0: no DONE expected (e.g. aborted by reset).
    task automatic start_op(input logic [31:0] ir, input logic [31:0] base, input int lat);
        IR    = ir;
        BASE  = base;
        START = 1'b1;
        if (lat >= 0) done_q.push_back(cyc + lat);
        tick();
        START = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
        tick();
        tick();
    endtask

    task automatic wait_mfa();
        for (int i = 0; i < 50 && !MFA; i++) tick();
    endtask

    initial begin
        RESET_N = 1'b1;
        START   = 1'b0;
        MOC     = 1'b0;
        IR      = '0;
        BASE    = '0;
        #2 RESET_N = 1'b0;
        #2 check("reset_outputs", outs(), '0);
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        tick();

        // LDMIA r10!, {r2,r5,r7,r13}
        MOC = 1'b1;
        exp_x(32'h1000, 4'd2, 1'b1); exp_x(32'h1004, 4'd5, 1'b1);
        exp_x(32'h1008, 4'd7, 1'b1); exp_x(32'h100C, 4'd13, 1'b1);
        ld_q.push_back(4'd2); ld_q.push_back(4'd5); ld_q.push_back(4'd7); ld_q.push_back(4'd13);
        exp_wb(4'd10, 32'h1010);
        start_op(32'hE8BA20A4, 32'h1000, 10);
        wait_idle("ldmia");

        // STMDB r13!, {r4,r14}
        exp_x(32'h1FF8, 4'd4, 1'b0); exp_x(32'h1FFC, 4'd14, 1'b0);
        exp_wb(4'd13, 32'h1FF8);
        start_op(32'hE92D4010, 32'h2000, 6);
        wait_idle("stmdb");

        // LDMIB r2!, {r0,r1}
        exp_x(32'h104, 4'd0, 1'b1); exp_x(32'h108, 4'd1, 1'b1);
        ld_q.push_back(4'd0); ld_q.push_back(4'd1);
        exp_wb(4'd2, 32'h108);
        start_op(32'hE9B20003, 32'h100, 6);
        wait_idle("ldmib");

        // LDMDA r2!, {r0,r1}
        exp_x(32'h0FC, 4'd0, 1'b1); exp_x(32'h100, 4'd1, 1'b1);
        ld_q.push_back(4'd0); ld_q.push_back(4'd1);
        exp_wb(4'd2, 32'h0F8);
        start_op(32'hE8320003, 32'h100, 6);
        wait_idle("ldmda");

        // MOC held low for 5 cycles on the second transfer adds 4 cycles.
        MOC = 1'b0;
        exp_x(32'h3000, 4'd2, 1'b1); exp_x(32'h3004, 4'd5, 1'b1);
        exp_x(32'h3008, 4'd7, 1'b1); exp_x(32'h300C, 4'd13, 1'b1);
        ld_q.push_back(4'd2); ld_q.push_back(4'd5); ld_q.push_back(4'd7); ld_q.push_back(4'd13);
        exp_wb(4'd10, 32'h3010);
        start_op(32'hE8BA20A4, 32'h3000, 14);
        wait_mfa();
        MOC = 1'b1;
        tick();
        MOC = 1'b0;
        wait_mfa();
        repeat (4) tick();
        MOC = 1'b1;
        wait_idle("stall");

        // Empty list, then START held across DONE: accepted only once back in IDLE.
        start_op(32'hE8BA0000, 32'h500, 2);
        for (int i = 0; i < 20 && !DONE; i++) tick();
        START = 1'b1;
        done_q.push_back(cyc + 3);
        tick();
        tick();
        START = 1'b0;
        wait_idle("empty_restart");

        // Not a block transfer: ignored.
        IR    = 32'hE0810002;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("illegal_busy", BUSY, 1'b0);
            tick();
        end

        // Reset during the second transfer of a 4-register load.
        exp_x(32'h4000, 4'd2, 1'b1);
        ld_q.push_back(4'd2);
        start_op(32'hE8BA20A4, 32'h4000, -1);
        tick();
        tick();
        tick();
        check("rst_pre_mfa", MFA, 1'b1);
        #1 RESET_N = 1'b0;
        #1 check("rst_async_outputs", outs(), '0);
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        check("rst_idle_busy", BUSY, 1'b0);

        exp_x(32'h104, 4'd0, 1'b1); exp_x(32'h108, 4'd1, 1'b1);
        ld_q.push_back(4'd0); ld_q.push_back(4'd1);
        exp_wb(4'd2, 32'h108);
        start_op(32'hE9B20003, 32'h100, 6);
        wait_idle("after_reset");

        // LDMIA r1!, {r0,r1}: loaded value wins, no write-back.
        exp_x(32'h200, 4'd0, 1'b1); exp_x(32'h204, 4'd1, 1'b1);
        ld_q.push_back(4'd0); ld_q.push_back(4'd1);
        start_op(32'hE8B10003, 32'h200, 6);
        wait_idle("rn_in_list");

        check("xfer_left", xfer_q.size(), 0);
        check("ld_left", ld_q.size(), 0);
        check("wb_left", wb_q.size(), 0);
        check("done_left", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
